// File: rtl/det_pkg.sv
// Shared state encoding, sizing constants and status codes for the matrix fetch sequencer.
// Pure declarations: no latency, no flow control.
package det_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        REQ   = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_e;

    localparam int MAX_DIM         = 32;
    localparam int ROW_STRIDE      = 32;
    localparam int MAX_BURST       = 4;
    localparam int MAX_OUTSTANDING = 8;

    localparam logic DET_STATUS_READY = 1'b0;
    localparam logic DET_STATUS_BUSY  = 1'b1;

endpackage

// File: rtl/matrix_wr_addr_gen.sv
// Row/column write pointer for the local matrix RAM; address is combinational from the counters.
// Advances one word per adv_i with no stall of its own; last_o marks element (N-1, N-1).
module matrix_wr_addr_gen
    import det_pkg::*;
#(
    parameter int RAM_AW = 10
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              clr_i,
    input  logic [5:0]        n_i,
    input  logic              adv_i,
    output logic [RAM_AW-1:0] addr_o,
    output logic              last_o
);

    logic [4:0] row_q, row_d;
    logic [4:0] col_q, col_d;
    logic [5:0] n_m1;
    logic       col_end;

    assign n_m1    = n_i - 6'd1;
    assign col_end = ({1'b0, col_q} == n_m1);
    assign last_o  = col_end && ({1'b0, row_q} == n_m1);
    assign addr_o  = RAM_AW'(32'(row_q) * ROW_STRIDE + 32'(col_q));

    always_comb begin
        row_d = row_q;
        col_d = col_q;
        if (clr_i) begin
            row_d = 5'd0;
            col_d = 5'd0;
        end else if (adv_i) begin
            if (col_end) begin
                col_d = 5'd0;
                row_d = row_q + 5'd1;
            end else begin
                col_d = col_q + 5'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            row_q <= 5'd0;
            col_q <= 5'd0;
        end else begin
            row_q <= row_d;
            col_q <= col_d;
        end
    end

endmodule

// File: rtl/matrix_fetch_ctrl.sv
// Streams an N x N word matrix from Avalon memory into the local RAM using credit-limited bursts.
// RAM write lands one cycle after readdatavalid; bursts hold steady under waitrequest.
module matrix_fetch_ctrl #(
    parameter int MAX_BURST       = det_pkg::MAX_BURST,
    parameter int MAX_OUTSTANDING = det_pkg::MAX_OUTSTANDING,
    parameter int MAX_DIM         = det_pkg::MAX_DIM,
    parameter int RAM_AW          = 10
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [31:0]       base_ptr,
    input  logic [5:0]        mxsize,
    output logic              busy,
    output logic              done,
    output logic              error,
    output logic [31:0]       avm_address,
    output logic              avm_read,
    output logic [2:0]        avm_burstcount,
    input  logic              avm_waitrequest,
    input  logic [31:0]       avm_readdata,
    input  logic              avm_readdatavalid,
    output logic [RAM_AW-1:0] ram_addr,
    output logic [31:0]       ram_data,
    output logic              ram_we
);
    import det_pkg::*;

    state_e            state_q, state_d;
    logic [31:0]       addr_q, addr_d;
    logic [5:0]        n_q, n_d;
    logic [10:0]       req_rem_q, req_rem_d;
    logic [3:0]        out_q, out_d;
    logic              error_q, error_d;
    logic              ram_we_q;
    logic [31:0]       ram_data_q;
    logic [RAM_AW-1:0] ram_addr_q;
    logic              last_q;

    logic [2:0]        len;
    logic              size_ok;
    logic              start_ok;
    logic              credit_ok;
    logic              accept;
    logic              rd_vld;
    logic [RAM_AW-1:0] wr_addr;
    logic              wr_last;

    always_comb begin
        len = req_rem_q[2:0];
        if (req_rem_q >= 11'(MAX_BURST)) begin
            len = 3'(MAX_BURST);
        end
    end

    assign size_ok   = (mxsize != 6'd0) && (mxsize <= 6'(MAX_DIM));
    assign start_ok  = (state_q == IDLE) && start && size_ok;
    // Credit is judged on the registered count only, so the command cannot change under waitrequest.
    assign credit_ok = (5'(out_q) + 5'(len)) <= 5'(MAX_OUTSTANDING);
    assign avm_read  = (state_q == REQ) && credit_ok;
    assign accept    = avm_read && !avm_waitrequest;
    assign rd_vld    = avm_readdatavalid && ((state_q == REQ) || (state_q == DRAIN));

    assign avm_address    = addr_q;
    assign avm_burstcount = avm_read ? len : 3'd0;
    assign busy           = ((state_q == REQ) || (state_q == DRAIN)) ? DET_STATUS_BUSY
                                                                     : DET_STATUS_READY;
    assign done           = (state_q == DONE);
    assign error          = error_q;
    assign ram_we         = ram_we_q;
    assign ram_data       = ram_data_q;
    assign ram_addr       = ram_addr_q;

    always_comb begin
        state_d   = state_q;
        addr_d    = addr_q;
        n_d       = n_q;
        req_rem_d = req_rem_q;
        out_d     = out_q;
        error_d   = 1'b0;

        case (state_q)
            IDLE: begin
                if (start_ok) begin
                    addr_d    = base_ptr & ~32'h3;
                    n_d       = mxsize;
                    req_rem_d = 11'(mxsize) * 11'(mxsize);
                    state_d   = REQ;
                end else if (start) begin
                    error_d = 1'b1;
                end
            end
            REQ: begin
                if (accept) begin
                    addr_d    = addr_q + {27'd0, len, 2'b00};
                    req_rem_d = req_rem_q - 11'(len);
                    if (req_rem_q == 11'(len)) begin
                        state_d = DRAIN;
                    end
                end
            end
            DRAIN: begin
                // last_q is high in the cycle the final word is written to RAM.
                if (last_q) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (accept) begin
            out_d = out_d + 4'(len);
        end
        if (rd_vld) begin
            out_d = out_d - 4'd1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= IDLE;
            addr_q     <= 32'd0;
            n_q        <= 6'd0;
            req_rem_q  <= 11'd0;
            out_q      <= 4'd0;
            error_q    <= 1'b0;
            ram_we_q   <= 1'b0;
            ram_data_q <= 32'd0;
            ram_addr_q <= '0;
            last_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            addr_q    <= addr_d;
            n_q       <= n_d;
            req_rem_q <= req_rem_d;
            out_q     <= out_d;
            error_q   <= error_d;
            ram_we_q  <= rd_vld;
            last_q    <= rd_vld && wr_last;
            if (rd_vld) begin
                ram_data_q <= avm_readdata;
                ram_addr_q <= wr_addr;
            end
        end
    end

    matrix_wr_addr_gen #(
        .RAM_AW (RAM_AW)
    ) u_wr_addr_gen (
        .clk    (clk),
        .reset  (reset),
        .clr_i  (start_ok),
        .n_i    (n_q),
        .adv_i  (rd_vld),
        .addr_o (wr_addr),
        .last_o (wr_last)
    );

endmodule

// File: tb/tb_matrix_fetch_ctrl.sv
// Bench for matrix_fetch_ctrl: Avalon slave model with latency/stall control and a RAM-write scoreboard.
module tb_matrix_fetch_ctrl;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        start = 1'b0;
    logic [31:0] base_ptr = 32'd0;
    logic [5:0]  mxsize = 6'd0;
    logic        busy, done, error;
    logic [31:0] avm_address;
    logic        avm_read;
    logic [2:0]  avm_burstcount;
    logic        avm_waitrequest = 1'b0;
    logic [31:0] avm_readdata = 32'd0;
    logic        avm_readdatavalid = 1'b0;
    logic [9:0]  ram_addr;
    logic [31:0] ram_data;
    logic        ram_we;

    typedef struct {logic [31:0] data; int ready; bit stale;} pend_t;
    typedef struct {logic [31:0] addr; logic [2:0] cnt;} burst_t;
    typedef struct {logic [9:0] addr; logic [31:0] data;} wr_t;

    pend_t  pend_q[$];
    burst_t exp_burst_q[$];
    wr_t    exp_wr_q[$];

    int n_checks = 0;
    int n_pass   = 0;
    int cyc      = 0;

    int lat = 1;
    int stall_left = 0;
    int stall_seen = 0;
    logic [31:0] hold_addr;
    logic [2:0]  hold_cnt;
    bit          stall_acc_flag = 0;
    int          stall_acc_seen = 0;
    logic [31:0] stall_acc_addr;
    logic [2:0]  stall_acc_cnt;
    int out_cnt = 0;
    int max_out = 0;
    logic [31:0] cur_base = 32'd0;
    logic [31:0] salt = 32'd0;

    int done_cnt = 0, err_cnt = 0, busy_cyc = 0, read_cyc = 0, we_cnt = 0;
    int done_cyc = 0, last_we_cyc = 0;
    logic [9:0] last_we_addr = 10'd0;

    matrix_fetch_ctrl dut (
        .clk               (clk),
        .reset             (reset),
        .start             (start),
        .base_ptr          (base_ptr),
        .mxsize            (mxsize),
        .busy              (busy),
        .done              (done),
        .error             (error),
        .avm_address       (avm_address),
        .avm_read          (avm_read),
        .avm_burstcount    (avm_burstcount),
        .avm_waitrequest   (avm_waitrequest),
        .avm_readdata      (avm_readdata),
        .avm_readdatavalid (avm_readdatavalid),
        .ram_addr          (ram_addr),
        .ram_data          (ram_data),
        .ram_we            (ram_we)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Output monitor: event counters plus the RAM-write scoreboard.
    wr_t mon_e;
    always @(negedge clk) begin
        if (done)     begin done_cnt++; done_cyc = cyc; end
        if (error)    err_cnt++;
        if (busy)     busy_cyc++;
        if (avm_read) read_cyc++;
        if (ram_we) begin
            we_cnt++;
            last_we_cyc  = cyc;
            last_we_addr = ram_addr;
            n_checks++;
            if (exp_wr_q.size() == 0) begin
                $display("FAIL unexpected_write: got addr=%0d data=%h, required no write", ram_addr, ram_data);
            end else begin
                mon_e = exp_wr_q.pop_front();
                if (ram_addr !== mon_e.addr || ram_data !== mon_e.data)
                    $display("FAIL ram_write: got addr=%0d data=%h, required addr=%0d data=%h",
                             ram_addr, ram_data, mon_e.addr, mon_e.data);
                else n_pass++;
            end
        end
    end

    // Avalon slave: decides waitrequest/readdatavalid for the coming edge.
    pend_t  sl_p;
    burst_t sl_b;
    always @(negedge clk) begin
        if (!reset) begin
            foreach (pend_q[i]) pend_q[i].stale = 1'b1;
            out_cnt = 0;
        end
        if (stall_left > 0 && (avm_read || stall_seen > 0)) begin
            avm_waitrequest = 1'b1;
            if (stall_seen == 0) begin
                hold_addr = avm_address;
                hold_cnt  = avm_burstcount;
            end else begin
                n_checks++;
                if ({avm_read, avm_address, avm_burstcount} !== {1'b1, hold_addr, hold_cnt})
                    $display("FAIL stall_hold: got read=%b addr=%h cnt=%0d, required read=1 addr=%h cnt=%0d",
                             avm_read, avm_address, avm_burstcount, hold_addr, hold_cnt);
                else n_pass++;
            end
            stall_seen++;
            stall_left--;
        end else begin
            avm_waitrequest = 1'b0;
            if (avm_read) begin
                if (stall_seen > 0 && !stall_acc_flag) begin
                    stall_acc_flag = 1;
                    stall_acc_seen = stall_seen;
                    stall_acc_addr = avm_address;
                    stall_acc_cnt  = avm_burstcount;
                end
                n_checks++;
                if (exp_burst_q.size() == 0) begin
                    $display("FAIL unexpected_burst: got addr=%h cnt=%0d, required no burst", avm_address, avm_burstcount);
                end else begin
                    sl_b = exp_burst_q.pop_front();
                    if (avm_address !== sl_b.addr || avm_burstcount !== sl_b.cnt)
                        $display("FAIL burst_cmd: got addr=%h cnt=%0d, required addr=%h cnt=%0d",
                                 avm_address, avm_burstcount, sl_b.addr, sl_b.cnt);
                    else n_pass++;
                end
                n_checks++;
                if (out_cnt + int'(avm_burstcount) > 8)
                    $display("FAIL credit: got outstanding %0d after burst, required <= 8", out_cnt + int'(avm_burstcount));
                else n_pass++;
                for (int i = 0; i < int'(avm_burstcount); i++) begin
                    sl_p.data  = ((avm_address + 32'(4 * i) - cur_base) >> 2) + 32'd1 + salt;
                    sl_p.ready = cyc + lat;
                    sl_p.stale = 1'b0;
                    pend_q.push_back(sl_p);
                end
                out_cnt += int'(avm_burstcount);
                if (out_cnt > max_out) max_out = out_cnt;
            end
        end
        if (pend_q.size() > 0 && pend_q[0].ready <= cyc) begin
            sl_p = pend_q.pop_front();
            avm_readdatavalid = 1'b1;
            avm_readdata      = sl_p.data;
            if (!sl_p.stale) out_cnt--;
        end else begin
            avm_readdatavalid = 1'b0;
            avm_readdata      = 32'hDEAD_BEEF;
        end
    end

    task automatic push_expected(input int n, input logic [31:0] base, input logic [31:0] s);
        wr_t    e;
        burst_t b;
        int     rem = n * n;
        logic [31:0] a = base & ~32'h3;
        cur_base = a;
        salt     = s;
        for (int k = 0; k < n * n; k++) begin
            e.addr = 10'((k / n) * 32 + (k % n));
            e.data = 32'(k + 1) + s;
            exp_wr_q.push_back(e);
        end
        while (rem > 0) begin
            b.cnt  = 3'((rem > 4) ? 4 : rem);
            b.addr = a;
            exp_burst_q.push_back(b);
            a   = a + 32'(4 * int'(b.cnt));
            rem = rem - int'(b.cnt);
        end
    endtask

    task automatic do_start(input int n, input logic [31:0] base);
        @(negedge clk); #1;
        start    = 1'b1;
        mxsize   = 6'(n);
        base_ptr = base;
        @(negedge clk); #1;
        start = 1'b0;
    endtask

    task automatic wait_done(input string nm, input int d0);
        int k = 0;
        while (done_cnt == d0 && k < 3000) begin
            @(negedge clk); #1;
            k++;
        end
        n_checks++;
        if (done_cnt == d0) $display("FAIL %s_timeout: got no done in %0d cycles, required done", nm, k);
        else n_pass++;
        repeat (5) @(negedge clk);
        #1;
        n_checks++;
        if (done_cnt !== d0 + 1) $display("FAIL %s_done_count: got %0d pulses, required 1", nm, done_cnt - d0);
        else n_pass++;
        n_checks++;
        if (done_cyc !== last_we_cyc + 1)
            $display("FAIL %s_done_timing: got done at cycle %0d, required %0d", nm, done_cyc, last_we_cyc + 1);
        else n_pass++;
        n_checks++;
        if (exp_wr_q.size() != 0 || exp_burst_q.size() != 0)
            $display("FAIL %s_leftover: got %0d writes %0d bursts pending, required 0 0", nm, exp_wr_q.size(), exp_burst_q.size());
        else n_pass++;
        n_checks++;
        if (busy !== 1'b0) $display("FAIL %s_busy_end: got busy=%b, required 0", nm, busy);
        else n_pass++;
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk);
        n_checks++;
        if ({busy, done, error, avm_read, avm_address, avm_burstcount, ram_we, ram_addr, ram_data} !== '0)
            $display("FAIL reset_outputs: got busy=%b read=%b addr=%h ram_we=%b, required all 0", busy, avm_read, avm_address, ram_we);
        else n_pass++;
        #1 reset = 1'b1;
        @(negedge clk);
        n_checks++;
        if ({busy, done, error, avm_read, avm_address, avm_burstcount, ram_we, ram_addr, ram_data} !== '0)
            $display("FAIL idle_outputs: got busy=%b read=%b addr=%h ram_we=%b, required all 0", busy, avm_read, avm_address, ram_we);
        else n_pass++;
    endtask

    task automatic test_n2();
        int d0 = done_cnt;
        lat = 1;
        push_expected(2, 32'h1000, 32'd0);
        do_start(2, 32'h1000);
        n_checks++;
        if (busy !== 1'b1) $display("FAIL n2_busy: got busy=%b, required 1", busy);
        else n_pass++;
        wait_done("n2", d0);
    endtask

    task automatic test_n3();
        int d0 = done_cnt;
        push_expected(3, 32'h2003, 32'h0010_0000);
        do_start(3, 32'h2003);
        wait_done("n3", d0);
        n_checks++;
        if (last_we_addr !== 10'd66) $display("FAIL n3_last_addr: got %0d, required 66", last_we_addr);
        else n_pass++;
    endtask

    task automatic test_stall();
        int d0 = done_cnt;
        stall_seen = 0;
        stall_acc_flag = 0;
        stall_left = 5;
        push_expected(2, 32'h1000, 32'd0);
        do_start(2, 32'h1000);
        wait_done("stall", d0);
        n_checks++;
        if (stall_acc_seen !== 5 || stall_acc_addr !== 32'h1000 || stall_acc_cnt !== 3'd4)
            $display("FAIL stall_accept: got after %0d stalls addr=%h cnt=%0d, required 5 1000 4",
                     stall_acc_seen, stall_acc_addr, stall_acc_cnt);
        else n_pass++;
    endtask

    task automatic test_latency();
        int d0 = done_cnt;
        int w0 = we_cnt;
        lat = 20;
        max_out = 0;
        push_expected(8, 32'h8000, 32'h00AB_0000);
        do_start(8, 32'h8000);
        wait_done("lat20", d0);
        n_checks++;
        if (max_out > 8) $display("FAIL lat20_outstanding: got peak %0d, required <= 8", max_out);
        else n_pass++;
        n_checks++;
        if (we_cnt - w0 !== 64) $display("FAIL lat20_writes: got %0d, required 64", we_cnt - w0);
        else n_pass++;
        lat = 1;
    endtask

    task automatic test_reject();
        int sizes[2] = '{0, 33};
        foreach (sizes[i]) begin
            int e0 = err_cnt;
            int b0 = busy_cyc;
            int r0 = read_cyc;
            do_start(sizes[i], 32'h9000);
            repeat (5) @(negedge clk);
            #1;
            n_checks++;
            if (err_cnt !== e0 + 1) $display("FAIL reject_error_n%0d: got %0d pulses, required 1", sizes[i], err_cnt - e0);
            else n_pass++;
            n_checks++;
            if (busy_cyc !== b0) $display("FAIL reject_busy_n%0d: got %0d busy cycles, required 0", sizes[i], busy_cyc - b0);
            else n_pass++;
            n_checks++;
            if (read_cyc !== r0) $display("FAIL reject_read_n%0d: got %0d read cycles, required 0", sizes[i], read_cyc - r0);
            else n_pass++;
        end
    endtask

    task automatic test_ignore_start();
        int d0 = done_cnt;
        int e0 = err_cnt;
        push_expected(3, 32'h4000, 32'h0020_0000);
        do_start(3, 32'h4000);
        repeat (2) @(negedge clk);
        do_start(2, 32'h5000);
        wait_done("ignore", d0);
        repeat (20) @(negedge clk);
        #1;
        n_checks++;
        if (done_cnt !== d0 + 1 || err_cnt !== e0)
            $display("FAIL ignore_second: got %0d done %0d error, required 1 0", done_cnt - d0, err_cnt - e0);
        else n_pass++;
    endtask

    task automatic test_reset_mid();
        int w0 = we_cnt;
        int w1;
        int k = 0;
        int d0;
        lat = 3;
        push_expected(4, 32'h3000, 32'h0030_0000);
        do_start(4, 32'h3000);
        while (we_cnt - w0 < 5 && k < 500) begin
            @(negedge clk); #1;
            k++;
        end
        n_checks++;
        if (we_cnt - w0 < 5) $display("FAIL midreset_progress: got %0d writes, required 5", we_cnt - w0);
        else n_pass++;
        reset = 1'b0;
        #1;
        n_checks++;
        if ({busy, done, error, avm_read, avm_address, avm_burstcount, ram_we, ram_addr, ram_data} !== '0)
            $display("FAIL midreset_outputs: got busy=%b read=%b addr=%h ram_we=%b, required all 0", busy, avm_read, avm_address, ram_we);
        else n_pass++;
        exp_wr_q.delete();
        exp_burst_q.delete();
        repeat (2) @(negedge clk);
        #1 reset = 1'b1;
        w1 = we_cnt;
        repeat (20) @(negedge clk);
        #1;
        n_checks++;
        if (we_cnt !== w1) $display("FAIL midreset_stale: got %0d writes, required 0", we_cnt - w1);
        else n_pass++;
        lat = 1;
        d0 = done_cnt;
        push_expected(2, 32'h6000, 32'h0040_0000);
        do_start(2, 32'h6000);
        wait_done("after_reset", d0);
    endtask

    initial begin
        test_reset();
        test_n2();
        test_n3();
        test_stall();
        test_latency();
        test_reject();
        test_ignore_start();
        test_reset_mid();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/matrix_fetch_ctrl.md
Name: matrix_fetch_ctrl

Overview:
Burst-read sequencer that streams an N x N matrix of 32-bit words from Avalon memory into the local matrix RAM. The RAM uses a row-major layout with a fixed row stride of 32 words. It replaces single-word fetching: it issues bursts of up to 4 words, limits outstanding reads, and tracks the row/column write position. It sits between the CPU-facing register block (start/ptr/len) and the Avalon master port plus RAM port A.

Parameters:
MAX_BURST, 4, maximum words per Avalon burst
MAX_OUTSTANDING, 8, maximum words requested but not yet returned
MAX_DIM, 32, largest legal matrix dimension; also the RAM row stride
RAM_AW, 10, RAM word-address width

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-low reset
start  in  1  one-cycle pulse; begins a fetch
base_ptr  in  32  byte address of matrix element (0,0); bits [1:0] are ignored and treated as 0
mxsize  in  6  matrix dimension N, sampled on start
busy  out  1  high from accepted start until done/error
done  out  1  one-cycle pulse, in the cycle after the last RAM write
error  out  1  one-cycle pulse when start is rejected (N = 0 or N > MAX_DIM)
avm_address  out  32  byte address of the burst
avm_read  out  1  read request
avm_burstcount  out  3  words in the current burst (1..4)
avm_waitrequest  in  1  slave stall
avm_readdata  in  32  returned word
avm_readdatavalid  in  1  returned-word strobe
ram_addr  out  RAM_AW  RAM write address = row*32 + col
ram_data  out  32  RAM write data
ram_we  out  1  RAM write enable

Behaviour:
- Reset (async, active-low): state IDLE; all outputs 0; all counters 0.
- States:
  - IDLE: start with 1 <= N <= 32 latches base_ptr, N and total = N*N (11 bits), then goes to REQ; busy = 1 from the next cycle. start with an illegal N pulses error for one cycle, stays in IDLE, issues no reads.
  - REQ: issue bursts, moving to DRAIN when remaining-to-request = 0.
  - DRAIN: wait until received == total, then go to DONE.
  - DONE: done = 1 for one cycle, busy = 0, back to IDLE.
- start in any state other than IDLE is ignored.
- Burst length: len = min(MAX_BURST, remaining-to-request).
- Issue condition: a burst is presented only when outstanding + len <= MAX_OUTSTANDING.
- Burst command hold: avm_read, avm_address and avm_burstcount are held stable while avm_waitrequest = 1.
- Burst acceptance: a burst is accepted on a clk edge with avm_read = 1 and avm_waitrequest = 0. On acceptance:
  - address += 4*len;
  - remaining-to-request -= len;
  - outstanding += len.
- Next command after acceptance: the next burst may be presented in the following cycle, with no bubble required. avm_read drops in the cycle after the last accepted burst, or when the credit check fails.
- Returned data: each avm_readdatavalid decrements outstanding by 1. Acceptance and readdatavalid in the same cycle give a net outstanding change of len - 1.
- RAM write: registered, 1-cycle latency. ram_we = 1 in the cycle after readdatavalid, with ram_data = the returned word and ram_addr = row*32 + col.
- Row/column counters: col increments per word; at col == N-1 it wraps to 0 and row increments. The first write goes to address 0.
- Stale data: avm_readdatavalid in IDLE or DONE is ignored (no RAM write, no counter change).
- Arithmetic: outstanding is 4 bits, with MAX_OUTSTANDING <= 8 guaranteed. Address arithmetic is modulo 2^32.
- Reset asserted mid-transfer clears everything immediately. Reads still in flight return later and are ignored, since the block is then in IDLE.

Decomposition:
- Shared package det_pkg:
  - state enum: IDLE, REQ, DRAIN, DONE;
  - constants: MAX_DIM, ROW_STRIDE = 32, MAX_BURST, MAX_OUTSTANDING;
  - status codes: DET_STATUS_READY = 0, DET_STATUS_BUSY = 1.
- One natural sub-module, matrix_wr_addr_gen: holds the row/col counters, computes row*32+col and asserts its last-word flag. The FSM, issue logic and credit counter stay in the top module.

Test Plan:
- N=2, base 0x1000, zero-wait slave with data 1..4: one burst (addr 0x1000, count 4); RAM writes 0→1, 1→2, 32→3, 33→4; done one cycle after the last write.
- N=3, base 0x2000: bursts of 4, 4, 1 at 0x2000, 0x2010, 0x2020; 9 writes ending at ram_addr 66; exactly one done pulse.
- avm_waitrequest held high 5 cycles on the first burst: address, read and burstcount stay constant; the burst is accepted on the 6th cycle; results match the unstalled run.
- N=8 with data latency 20 cycles: outstanding never exceeds 8 (at most 2 bursts in flight); all 64 words are written in order.
- Rejection and ignoring: start with N=0 or N=33 gives an error pulse, busy stays 0, no avm_read. start asserted again while busy is ignored, with no second done.
- Reset low mid-transfer (N=4, after 5 words): all outputs are 0 immediately. Late readdatavalid gives no ram_we. A new start with N=2 then completes normally.
